// File: rtl/histogram_accumulator_pkg.sv
// Shared types and constants for the 256-bin event histogram: FSM state
// encoding, default widths, bin count and counter full scale.
package histogram_accumulator_pkg;

  localparam int HIST_ADDR_W = 8;
  localparam int HIST_CNT_W  = 16;
  localparam int DEPTH       = 1 << HIST_ADDR_W;

  localparam logic [HIST_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]            DROP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INC_RD   = 3'd1,
    INC_WR   = 3'd2,
    HOST_RD  = 3'd3,
    HOST_RSP = 3'd4,
    CLR      = 3'd5
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == DROP_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/histogram_accumulator_if.sv
// Bundle of distributer, host-read and clear signals for the histogram block.
interface histogram_accumulator_if #(
  parameter int ADDR_W = histogram_accumulator_pkg::HIST_ADDR_W,
  parameter int CNT_W  = histogram_accumulator_pkg::HIST_CNT_W
);
  import histogram_accumulator_pkg::*;

  // Handshakes: bin_add is a level strobe whose rising edge is one event.
  // rd_req/clr_req are single-cycle requests, each held one deep until
  // serviced; rd_valid and clr_done are single-cycle completions with no
  // backpressure. busy is high whenever the FSM is outside IDLE.
  logic [ADDR_W-1:0] bin_addr;
  logic              bin_add;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              clr_req;
  logic              clr_done;
  logic              busy;
  logic              sat_flag;
  logic [7:0]        drop_cnt;
  state_t            state;

  modport master (
    output bin_addr, bin_add, rd_req, rd_addr, clr_req,
    input  rd_data, rd_valid, clr_done, busy, sat_flag, drop_cnt, state
  );

  modport slave (
    input  bin_addr, bin_add, rd_req, rd_addr, clr_req,
    output rd_data, rd_valid, clr_done, busy, sat_flag, drop_cnt, state
  );

endinterface

// File: rtl/histogram_accumulator_hist_ram.sv
// Single-port synchronous RAM holding the bin counters; one-cycle read
// latency, read-before-write, no reset so it maps onto block RAM.
module hist_ram #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  wdata,
  output logic [CNT_W-1:0]  q
);

  logic [CNT_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Event histogram: rising edges of bin_add bump a saturating counter in RAM
// via read-modify-write, arbitrated against host reads and a full clear.
module histogram_accumulator
  import histogram_accumulator_pkg::*;
#(
  parameter int ADDR_W = HIST_ADDR_W,
  parameter int CNT_W  = HIST_CNT_W
) (
  input logic                   clk,
  input logic                   rst_n,
  histogram_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0]  cnt_max  = '1;
  localparam logic [ADDR_W-1:0] last_bin = '1;

  state_t            state, state_next;
  logic              bin_add_d;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              clr_pend;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_done_q;
  logic              sat_q;
  logic [7:0]        drop_q;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CNT_W-1:0]  ram_wdata, ram_q;
  logic [CNT_W:0]    inc_sum;
  logic [CNT_W-1:0]  inc_val;

  logic event_new, event_take, event_drop;
  logic inc_any, rd_any, clr_any, clr_grant, rd_grant;

  assign event_new  = bus.bin_add & ~bin_add_d;
  assign event_take = event_new & ~pend_valid;
  assign event_drop = event_new & pend_valid;

  // New requests are seen combinationally so IDLE can start them the next cycle.
  assign inc_any   = pend_valid | event_take;
  assign clr_any   = clr_pend | bus.clr_req;
  assign rd_any    = rd_pend | bus.rd_req;
  assign clr_grant = (state == IDLE) & clr_any;
  assign rd_grant  = (state == IDLE) & ~clr_any & ~inc_any & rd_any;

  assign inc_sum = {1'b0, ram_q} + {{CNT_W{1'b0}}, 1'b1};
  assign inc_val = inc_sum[CNT_W] ? cnt_max : inc_sum[CNT_W-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clr_any)      state_next = CLR;
        else if (inc_any) state_next = INC_RD;
        else if (rd_any)  state_next = HOST_RD;
      end
      INC_RD:   state_next = INC_WR;
      INC_WR:   state_next = IDLE;
      HOST_RD:  state_next = HOST_RSP;
      HOST_RSP: state_next = IDLE;
      CLR:      if (clr_ptr == last_bin) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = pend_addr;
    ram_wdata = '0;
    case (state)
      INC_RD: ram_en = 1'b1;
      INC_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = inc_val;
      end
      HOST_RD: begin
        ram_en   = 1'b1;
        ram_addr = rd_addr_q;
      end
      CLR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_add_d  <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      rd_pend    <= 1'b0;
      rd_addr_q  <= '0;
      clr_pend   <= 1'b0;
      clr_ptr    <= '0;
      clr_done_q <= 1'b0;
      sat_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      bin_add_d <= bus.bin_add;

      if (event_take) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.bin_addr;
      end else if (state == INC_WR) begin
        pend_valid <= 1'b0;
      end

      if (rd_grant)                 rd_pend <= 1'b0;
      else if (bus.rd_req)          rd_pend <= 1'b1;
      if (bus.rd_req && !rd_pend)   rd_addr_q <= bus.rd_addr;

      if (clr_grant)                clr_pend <= 1'b0;
      else if (bus.clr_req)         clr_pend <= 1'b1;

      if (clr_grant)                clr_ptr <= '0;
      else if (state == CLR)        clr_ptr <= clr_ptr + 1'b1;
      clr_done_q <= (state == CLR) && (clr_ptr == last_bin);

      // Sticky status is wiped when a clear is granted; drops during CLR still count.
      if (clr_grant)                                sat_q <= 1'b0;
      else if (state == INC_WR && inc_val == cnt_max) sat_q <= 1'b1;

      if (clr_grant)       drop_q <= '0;
      else if (event_drop) drop_q <= sat_inc8(drop_q);
    end
  end

  hist_ram #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign bus.rd_valid = (state == HOST_RSP);
  assign bus.rd_data  = (state == HOST_RSP) ? ram_q : '0;
  assign bus.clr_done = clr_done_q;
  assign bus.busy     = (state != IDLE);
  assign bus.sat_flag = sat_q;
  assign bus.drop_cnt = drop_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed bench for histogram_accumulator; a 4-bit-counter copy shares the
// same stimulus so saturation is reachable in a few events.
module tb_histogram_accumulator;
  import histogram_accumulator_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  histogram_accumulator_if #(.ADDR_W(8), .CNT_W(16)) bus ();
  histogram_accumulator_if #(.ADDR_W(8), .CNT_W(4))  sat_bus ();

  assign sat_bus.bin_addr = bus.bin_addr;
  assign sat_bus.bin_add  = bus.bin_add;
  assign sat_bus.rd_req   = bus.rd_req;
  assign sat_bus.rd_addr  = bus.rd_addr;
  assign sat_bus.clr_req  = bus.clr_req;

  histogram_accumulator #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  histogram_accumulator #(.ADDR_W(8), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] addr, input int hi, input int lo);
    bus.bin_addr = addr;
    bus.bin_add  = 1'b1;
    tick(hi);
    bus.bin_add  = 1'b0;
    tick(lo);
  endtask

  task automatic do_clear(input string tag);
    int k;
    bit seen;
    bus.clr_req = 1'b1;
    tick(1);
    bus.clr_req = 1'b0;
    k = 1;
    seen = 1'b0;
    while (k < 400 && !seen) begin
      if (bus.clr_done) seen = 1'b1;
      else begin
        tick(1);
        k++;
      end
    end
    check({tag, " clr_done latency"}, k, 257);
    tick(1);
  endtask

  task automatic host_read(input string tag, input logic [7:0] addr,
                           output logic [15:0] data, output logic [3:0] sdata,
                           output int lat);
    bus.rd_addr = addr;
    bus.rd_req  = 1'b1;
    tick(1);
    bus.rd_req  = 1'b0;
    lat = 1;
    while (lat < 50 && !bus.rd_valid) begin
      tick(1);
      lat++;
    end
    check({tag, " rd_valid"}, bus.rd_valid, 1);
    data  = bus.rd_data;
    sdata = sat_bus.rd_data;
    tick(1);
  endtask

  // Per-cycle bin_add/bin_addr: events at cycles 0 and 3, third at 5 lands
  // while the second is still pending.
  logic       win_add  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] win_addr [8] = '{8'd20, 8'd20, 8'd21, 8'd21, 8'd21, 8'd22, 8'd22, 8'd22};

  initial begin
    logic [15:0] d;
    logic [3:0]  sd;
    int          lat;

    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.bin_addr = '0;
    bus.bin_add  = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.clr_req  = 1'b0;
    tick(3);

    check("reset rd_data",  bus.rd_data, 0);
    check("reset rd_valid", bus.rd_valid, 0);
    check("reset clr_done", bus.clr_done, 0);
    check("reset busy",     bus.busy, 0);
    check("reset sat_flag", bus.sat_flag, 0);
    check("reset drop_cnt", bus.drop_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    do_clear("init");
    host_read("bin0", 8'd0, d, sd, lat);
    check("bin0 after clear", d, 0);
    check("idle read latency", lat, 2);
    host_read("bin128", 8'd128, d, sd, lat);
    check("bin128 after clear", d, 0);
    host_read("bin255", 8'd255, d, sd, lat);
    check("bin255 after clear", d, 0);

    for (int i = 0; i < 5; i++) strobe(8'd128, 6, 14);
    host_read("five", 8'd128, d, sd, lat);
    check("bin128 five events", d, 5);
    host_read("nb127", 8'd127, d, sd, lat);
    check("bin127 untouched", d, 0);
    check("drop_cnt no overrun", bus.drop_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      bus.bin_addr = win_addr[i];
      bus.bin_add  = win_add[i];
      tick(1);
    end
    tick(5);
    host_read("w20", 8'd20, d, sd, lat);
    check("window bin20", d, 1);
    host_read("w21", 8'd21, d, sd, lat);
    check("window bin21", d, 1);
    host_read("w22", 8'd22, d, sd, lat);
    check("window dropped bin22", d, 0);
    check("window drop_cnt", bus.drop_cnt, 1);

    // Event and host read to bin 129 in the same cycle: increment wins.
    bus.bin_addr = 8'd129;
    bus.bin_add  = 1'b1;
    bus.rd_addr  = 8'd129;
    bus.rd_req   = 1'b1;
    tick(1);
    bus.rd_req = 1'b0;
    lat = 1;
    while (lat < 50 && !bus.rd_valid) begin
      if (lat == 6) bus.bin_add = 1'b0;
      tick(1);
      lat++;
    end
    check("coincident rd_valid", bus.rd_valid, 1);
    check("coincident rd_data", bus.rd_data, 1);
    bus.bin_add = 1'b0;
    tick(10);

    for (int i = 0; i < 14; i++) strobe(8'd10, 2, 2);
    tick(3);
    check("sat_flag below full scale", sat_bus.sat_flag, 0);
    strobe(8'd10, 2, 2);
    strobe(8'd10, 2, 2);
    tick(3);
    host_read("sat", 8'd10, d, sd, lat);
    check("narrow bin10 clamped", sd, 15);
    check("wide bin10 count", d, 16);
    check("narrow sat_flag set", sat_bus.sat_flag, 1);
    check("wide sat_flag clear", bus.sat_flag, 0);

    do_clear("scope");
    check("clear resets sat_flag", sat_bus.sat_flag, 0);
    check("clear resets drop_cnt", bus.drop_cnt, 0);
    host_read("post", 8'd10, d, sd, lat);
    check("bin10 after clear", d, 0);
    check("narrow bin10 after clear", sd, 0);

    bus.clr_req = 1'b1;
    tick(1);
    bus.clr_req = 1'b0;
    tick(100);
    check("busy mid clear", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midclr rd_data",  bus.rd_data, 0);
    check("midclr rd_valid", bus.rd_valid, 0);
    check("midclr clr_done", bus.clr_done, 0);
    check("midclr busy",     bus.busy, 0);
    check("midclr sat_flag", bus.sat_flag, 0);
    check("midclr drop_cnt", bus.drop_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_clear("after reset");
    host_read("final", 8'd128, d, sd, lat);
    check("bin128 after final clear", d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
